// File: rtl/exu_bjp_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exu_bjp_flush_ctrl
// Description : Commit-stage branch flush controller. Checks each committing
//               branch/jump against its front-end prediction. On a mispredict
//               it raises one redirect-and-flush request toward fetch and
//               stalls commit until fetch accepts it. It also keeps
//               wrap-around counters of committed branches and mispredicts.
// Ports       : clk, rst (async, active-high)
//               cmt_i_*   : commit slot (valid/ready, bjp flags, pc, imm)
//               flush_o_* : redirect request (valid/ready, target pc)
//               perf_*    : committed-branch / mispredict counters
// Revision    : 1.0 - initial release
// ============================================================================
module exu_bjp_flush_ctrl #(
    parameter int PC_SIZE = 32,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmt_i_valid,
    output logic               cmt_i_ready,
    input  logic               cmt_i_bjp,
    input  logic               cmt_i_bjp_prdt,
    input  logic               cmt_i_bjp_rslv,
    input  logic [PC_SIZE-1:0] cmt_i_pc,
    input  logic [XLEN-1:0]    cmt_i_imm,
    output logic               flush_o_valid,
    input  logic               flush_o_ready,
    output logic [PC_SIZE-1:0] flush_o_pc,
    output logic [CNT_W-1:0]   perf_bjp_cnt,
    output logic [CNT_W-1:0]   perf_mis_cnt
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t             r_state;
    logic [PC_SIZE-1:0] r_flush_pc;
    logic [CNT_W-1:0]   r_bjp_cnt;
    logic [CNT_W-1:0]   r_mis_cnt;

    logic               w_accept;
    logic               w_bjp;
    logic               w_mis;
    logic [PC_SIZE-1:0] w_target;

    // Handshake outputs come straight from the state register, so no input
    // can reach them combinationally.
    assign cmt_i_ready   = (r_state == S_IDLE);
    assign flush_o_valid = (r_state == S_FLUSH);
    assign flush_o_pc    = r_flush_pc;
    assign perf_bjp_cnt  = r_bjp_cnt;
    assign perf_mis_cnt  = r_mis_cnt;

    assign w_accept = cmt_i_valid & cmt_i_ready;
    // Gating by cmt_i_bjp keeps the prediction flags inert on non-branches.
    assign w_bjp    = w_accept & cmt_i_bjp;
    assign w_mis    = w_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);

    // Sums are PC_SIZE wide, so the carry out falls off naturally.
    assign w_target = cmt_i_bjp_rslv ? (cmt_i_pc + cmt_i_imm[PC_SIZE-1:0])
                                     : (cmt_i_pc + PC_SIZE'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_flush_pc <= '0;
            r_bjp_cnt  <= '0;
            r_mis_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mis) begin
                        r_state    <= S_FLUSH;
                        r_flush_pc <= w_target;
                    end
                end
                S_FLUSH: begin
                    if (flush_o_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Counters wrap freely at all-ones.
            if (w_bjp) begin
                r_bjp_cnt <= r_bjp_cnt + 1'b1;
            end
            if (w_mis) begin
                r_mis_cnt <= r_mis_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exu_bjp_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu_bjp_flush_ctrl
// Description : Self-checking bench for exu_bjp_flush_ctrl. Directed steps
//               followed by a randomized phase, checked each cycle against a
//               behavioural model (pending-request flag, target, counts).
//               Counters are built 4 bits wide so wrap-around is exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_bjp_flush_ctrl;

    localparam int PC_SIZE = 32;
    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               rst;
    logic               cmt_i_valid;
    logic               cmt_i_ready;
    logic               cmt_i_bjp;
    logic               cmt_i_bjp_prdt;
    logic               cmt_i_bjp_rslv;
    logic [PC_SIZE-1:0] cmt_i_pc;
    logic [XLEN-1:0]    cmt_i_imm;
    logic               flush_o_valid;
    logic               flush_o_ready;
    logic [PC_SIZE-1:0] flush_o_pc;
    logic [CNT_W-1:0]   perf_bjp_cnt;
    logic [CNT_W-1:0]   perf_mis_cnt;

    exu_bjp_flush_ctrl #(
        .PC_SIZE (PC_SIZE),
        .XLEN    (XLEN),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .cmt_i_valid    (cmt_i_valid),
        .cmt_i_ready    (cmt_i_ready),
        .cmt_i_bjp      (cmt_i_bjp),
        .cmt_i_bjp_prdt (cmt_i_bjp_prdt),
        .cmt_i_bjp_rslv (cmt_i_bjp_rslv),
        .cmt_i_pc       (cmt_i_pc),
        .cmt_i_imm      (cmt_i_imm),
        .flush_o_valid  (flush_o_valid),
        .flush_o_ready  (flush_o_ready),
        .flush_o_pc     (flush_o_pc),
        .perf_bjp_cnt   (perf_bjp_cnt),
        .perf_mis_cnt   (perf_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: is a request pending, what target, how many events.
    bit           m_pending;
    longint       m_target;
    int           m_bjp;
    int           m_mis;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ready"}, 64'(cmt_i_ready),   64'(!m_pending));
        chk({tag, ".fvld"},  64'(flush_o_valid), 64'(m_pending));
        chk({tag, ".fpc"},   64'(flush_o_pc),    64'(m_target));
        chk({tag, ".bjp"},   64'(perf_bjp_cnt),  64'(m_bjp % 16));
        chk({tag, ".mis"},   64'(perf_mis_cnt),  64'(m_mis % 16));
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_target  = 0;
        m_bjp     = 0;
        m_mis     = 0;
    endtask

    // Advance one clock: the model consumes the inputs present at the edge,
    // then the DUT is sampled 1 time unit later.
    task automatic cyc(input string tag);
        bit     acc;
        bit     was_pending;
        longint sum;
        was_pending = m_pending;
        acc = cmt_i_valid && !was_pending;
        if (acc && cmt_i_bjp) begin
            m_bjp++;
            if (cmt_i_bjp_prdt != cmt_i_bjp_rslv) begin
                m_mis++;
                m_pending = 1'b1;
                if (cmt_i_bjp_rslv)
                    sum = longint'(cmt_i_pc) + longint'(cmt_i_imm[PC_SIZE-1:0]);
                else
                    sum = longint'(cmt_i_pc) + 4;
                m_target = sum % (64'd1 << PC_SIZE);
            end
        end
        if (was_pending && flush_o_ready)
            m_pending = 1'b0;
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic quiet();
        cmt_i_valid    = 1'b0;
        cmt_i_bjp      = 1'b0;
        cmt_i_bjp_prdt = 1'b0;
        cmt_i_bjp_rslv = 1'b0;
        cmt_i_pc       = '0;
        cmt_i_imm      = '0;
        flush_o_ready  = 1'b0;
    endtask

    task automatic commit(input logic prdt, input logic rslv,
                          input logic [31:0] pc, input logic [31:0] imm);
        cmt_i_valid    = 1'b1;
        cmt_i_bjp      = 1'b1;
        cmt_i_bjp_prdt = prdt;
        cmt_i_bjp_rslv = rslv;
        cmt_i_pc       = pc;
        cmt_i_imm      = imm;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        quiet();
        rst = 1'b0;
        model_reset();

        // Reset, then 10 idle cycles.
        do_reset("reset");
        for (int i = 0; i < 10; i++) cyc("idle");

        // Three correctly predicted taken branches back to back.
        commit(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0010);
        for (int i = 0; i < 3; i++) cyc("correct");
        quiet();
        cyc("correct_after");
        chk("correct.bjp3", 64'(perf_bjp_cnt), 64'd3);

        // Taken mispredict with negative offset.
        commit(1'b0, 1'b1, 32'h8000_0100, 32'hFFFF_FFF0);
        cyc("mis_taken");
        quiet();
        chk("mis_taken.pc", 64'(flush_o_pc), 64'h8000_00F0);
        for (int i = 0; i < 4; i++) cyc("hold");
        flush_o_ready = 1'b1;
        cyc("handshake");
        flush_o_ready = 1'b0;
        chk("handshake.idle", 64'(cmt_i_ready), 64'd1);
        flush_o_ready = 1'b1;
        cyc("ready_in_idle");
        flush_o_ready = 1'b0;

        // Not-taken mispredict whose fall-through wraps to zero.
        do_reset("reset2");
        commit(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_1234);
        cyc("mis_wrap");
        quiet();
        chk("mis_wrap.pc", 64'(flush_o_pc), 64'h0);
        chk("mis_wrap.mis", 64'(perf_mis_cnt), 64'd1);

        // Stall: a mispredicting commit is presented during FLUSH.
        commit(1'b0, 1'b1, 32'h0000_2000, 32'h0000_0040);
        cyc("stall1");
        cyc("stall2");
        flush_o_ready = 1'b1;
        cyc("stall_hs");
        flush_o_ready = 1'b0;
        cyc("stall_accept");
        quiet();
        chk("stall.pc", 64'(flush_o_pc), 64'h0000_2040);
        flush_o_ready = 1'b1;
        cyc("stall_hs2");
        flush_o_ready = 1'b0;

        // Randomized traffic; flags are X on non-branches.
        for (int i = 0; i < 400; i++) begin
            cmt_i_valid   = ($urandom_range(0, 3) != 0);
            cmt_i_bjp     = ($urandom_range(0, 3) != 0);
            if (cmt_i_bjp) begin
                cmt_i_bjp_prdt = 1'($urandom);
                cmt_i_bjp_rslv = 1'($urandom);
            end else begin
                cmt_i_bjp_prdt = 1'bx;
                cmt_i_bjp_rslv = 1'bx;
            end
            cmt_i_pc      = $urandom;
            cmt_i_imm     = $urandom;
            flush_o_ready = ($urandom_range(0, 2) == 0);
            cyc("rand");
        end
        quiet();

        // Asynchronous reset between edges while a request is pending.
        commit(1'b1, 1'b0, 32'h0000_3000, 32'h0);
        cyc("pre_arst");
        quiet();
        chk("pre_arst.fvld", 64'(flush_o_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("arst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc("post_arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exu_bjp_flush_ctrl.md
# exu_bjp_flush_ctrl

Commit-stage branch flush controller for the execution unit. It accepts committing instructions, checks each branch/jump (bjp) against its front-end prediction, and on a mispredict issues a single redirect-and-flush request to the fetch unit. It stalls further commits until the fetch unit accepts that request. It also keeps wrap-around counters of committed branches and mispredicts for performance monitoring.

## Interface
- PC_SIZE, 32, width of PC and redirect target
- XLEN, 32, width of immediate; must satisfy XLEN >= PC_SIZE
- CNT_W, 32, width of performance counters
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmt_i_valid  in  1  commit slot holds an instruction
- cmt_i_ready  out  1  controller can accept a commit this cycle
- cmt_i_bjp  in  1  committing instruction is a branch/jump
- cmt_i_bjp_prdt  in  1  front end predicted taken
- cmt_i_bjp_rslv  in  1  EXU resolved taken
- cmt_i_pc  in  PC_SIZE  PC of committing instruction
- cmt_i_imm  in  XLEN  branch offset, already sign-extended to XLEN
- flush_o_valid  out  1  flush/redirect request pending
- flush_o_ready  in  1  fetch unit accepts flush
- flush_o_pc  out  PC_SIZE  redirect target
- perf_bjp_cnt  out  CNT_W  committed branches
- perf_mis_cnt  out  CNT_W  committed mispredicts

## Operation
- The FSM has two states. IDLE is the reset state. FLUSH holds a pending request.
- cmt_i_ready = (state == IDLE). flush_o_valid = (state == FLUSH). Both are decoded from registered state only, so there is no combinational path from any input to either output.
- A commit is accepted when cmt_i_valid & cmt_i_ready.
- Accepted commit with cmt_i_bjp = 0: no state change and no counter change.
- Accepted commit with cmt_i_bjp = 1:
  - perf_bjp_cnt increments by 1.
  - Mispredict means cmt_i_bjp_prdt != cmt_i_bjp_rslv.
  - On a mispredict, perf_mis_cnt increments by 1, the FSM moves IDLE -> FLUSH, and flush_o_pc is loaded.
- Target on mispredict:
  - If rslv = 1, target = cmt_i_pc + cmt_i_imm[PC_SIZE-1:0].
  - If rslv = 0, target = cmt_i_pc + 4.
  - Both sums are modulo 2^PC_SIZE; carry out is discarded.
- FLUSH: flush_o_valid is held at 1 and flush_o_pc is held stable until flush_o_valid & flush_o_ready. After that handshake the FSM returns FLUSH -> IDLE.
- Counters wrap to 0 after all-ones and never saturate.
- flush_o_pc retains its last loaded value while in IDLE. Consumers qualify it with flush_o_valid.
- The X-state of cmt_i_bjp_* when cmt_i_bjp = 0 is don't-care and has no effect.

## Timing
- Reset (async, immediate): state = IDLE, so cmt_i_ready = 1 and flush_o_valid = 0. flush_o_pc = 0, perf_bjp_cnt = 0, perf_mis_cnt = 0.
- Mispredict accepted in cycle N:
  - flush_o_valid = 1 and cmt_i_ready = 0 from cycle N+1.
  - Counters show the update from cycle N+1.
- Handshake in cycle M (flush_o_ready = 1 while in FLUSH): flush_o_valid = 0 and cmt_i_ready = 1 from cycle M+1.
  - Minimum commit-to-commit spacing around a mispredict is 2 cycles, when flush_o_ready is already high.
- flush_o_ready while in IDLE is ignored.
- cmt_i_valid while in FLUSH is not accepted; the upstream holds the instruction.
- Reset asserted while in FLUSH: the request is dropped immediately and the FSM is in IDLE after reset release. No flush is replayed.
- Back-to-back correctly predicted branches are accepted every cycle with no bubbles.

## Test plan
- Reset, then idle: after rst deassert, cmt_i_ready = 1, flush_o_valid = 0, and both counters = 0, held for 10 cycles.
- Correct prediction: commit bjp with prdt = 1, rslv = 1, pc = 0x8000_0000 for 3 consecutive cycles. Required: no flush, cmt_i_ready stays 1, perf_bjp_cnt = 3, perf_mis_cnt = 0.
- Mispredict, taken: pc = 0x8000_0100, imm = 0xFFFF_FFF0, prdt = 0, rslv = 1. Required next cycle: flush_o_valid = 1, flush_o_pc = 0x8000_00F0, cmt_i_ready = 0. Hold flush_o_ready = 0 for 4 cycles; flush_o_pc stays stable. Assert flush_o_ready for 1 cycle; next cycle IDLE.
- Mispredict, not taken, with wrap: pc = 0xFFFF_FFFC, prdt = 1, rslv = 0. Required: flush_o_pc = 0x0000_0000 and perf_mis_cnt = 1.
- Stall check: during FLUSH, drive cmt_i_valid = 1 with a bjp mispredict. Required: it is not accepted and counters are unchanged. After the handshake it is accepted on the first IDLE cycle and a new flush follows.
- Async reset mid-FLUSH: assert rst between clock edges. Required: flush_o_valid = 0 and cmt_i_ready = 1 before the next edge, and counters = 0.
